// File: rtl/imem_loader_pkg.sv
// Shared types and sizing constants for the instruction-memory loader.
// The state encoding is common to the loader and anything that observes it.
package imem_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      CHECK,
      DONE,
      ERROR
   } loader_state_t;

   localparam int IMEM_ADDR_W = 12;
   localparam int IMEM_BYTES  = 4096;

   // Length field on the wire is always a 16-bit little-endian count.
   localparam int LEN_W       = 16;

endpackage

// File: rtl/imem_loader.sv
// Byte-stream program loader: parses LEN_LO, LEN_HI, payload, XOR checksum and
// writes the payload into instruction memory while holding the CPU in reset.
module imem_loader
   import imem_pkg::*;
#(
   parameter int                       ADDRESS_WIDTH = IMEM_ADDR_W,
   parameter int                       DATA_WIDTH    = 8,
   parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [DATA_WIDTH-1:0]    rx_data,
   input  logic                     rx_valid,
   output logic                     rx_ready,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]    mem_wdata,
   output logic                     mem_we,
   output logic                     cpu_hold,
   output logic                     busy,
   output logic                     done,
   output logic                     error,
   output logic [ADDRESS_WIDTH:0]   byte_count
);

   // One extra bit so a full-capacity length (2**ADDRESS_WIDTH) is representable.
   localparam int                CMP_W    = LEN_W + 1;
   localparam logic [CMP_W-1:0]  CAPACITY = CMP_W'(1) << ADDRESS_WIDTH;

   loader_state_t              state_q, state_d;
   logic [LEN_W-1:0]           len_q, len_d;
   logic [ADDRESS_WIDTH:0]     count_q, count_d;
   logic [DATA_WIDTH-1:0]      csum_q, csum_d;
   logic                       done_q, done_d;
   logic                       error_q, error_d;
   logic                       we_q, we_d;
   logic [ADDRESS_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;

   logic                       xfer;
   logic [ADDRESS_WIDTH:0]     countNext;
   logic [CMP_W-1:0]           countNextExt;
   logic [CMP_W-1:0]           lenFullExt;
   logic [CMP_W-1:0]           lenExt;

   assign rx_ready     = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                         (state_q == DATA)   || (state_q == CHECK);
   assign xfer         = rx_valid && rx_ready;
   assign countNext    = count_q + {{ADDRESS_WIDTH{1'b0}}, 1'b1};
   assign countNextExt = CMP_W'(countNext);
   assign lenExt       = CMP_W'(len_q);
   assign lenFullExt   = CMP_W'({rx_data[7:0], len_q[7:0]});

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      count_d = count_q;
      csum_d  = csum_q;
      done_d  = done_q;
      error_d = error_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;

      unique case (state_q)
         IDLE, DONE, ERROR: begin
            if (start) begin
               state_d = LEN_LO;
               done_d  = 1'b0;
               error_d = 1'b0;
               count_d = '0;
               csum_d  = '0;
            end
         end

         LEN_LO: begin
            if (xfer) begin
               len_d[7:0] = rx_data[7:0];
               state_d    = LEN_HI;
            end
         end

         LEN_HI: begin
            if (xfer) begin
               len_d[15:8] = rx_data[7:0];
               if (lenFullExt > CAPACITY) begin
                  state_d = ERROR;
                  error_d = 1'b1;
               end else if (lenFullExt == '0) begin
                  state_d = CHECK;
               end else begin
                  state_d = DATA;
               end
            end
         end

         // Address is truncated to the memory width so BASE_ADDR + count wraps.
         DATA: begin
            if (xfer) begin
               we_d    = 1'b1;
               addr_d  = BASE_ADDR + count_q[ADDRESS_WIDTH-1:0];
               wdata_d = rx_data;
               count_d = countNext;
               csum_d  = csum_q ^ rx_data;
               if (countNextExt == lenExt) begin
                  state_d = CHECK;
               end
            end
         end

         CHECK: begin
            if (xfer) begin
               if (rx_data == csum_q) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ERROR;
                  error_d = 1'b1;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         len_q   <= '0;
         count_q <= '0;
         csum_q  <= '0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         count_q <= count_d;
         csum_q  <= csum_d;
         done_q  <= done_d;
         error_q <= error_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // The CPU stays held after a failed load so it never runs a partial image.
   assign busy       = rx_ready;
   assign cpu_hold   = rx_ready || (state_q == ERROR);
   assign done       = done_q;
   assign error      = error_q;
   assign byte_count = count_q;
   assign mem_we     = we_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a BASE_ADDR=0 instance and a BASE_ADDR=0xFFE
// instance share the same stimulus so address wrap is observed alongside normal loads.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  rx_data;
   logic        rx_valid;

   logic        rx_ready, mem_we, cpu_hold, busy, done, error;
   logic [11:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [12:0] byte_count;

   logic        wr_rx_ready, wr_mem_we, wr_cpu_hold, wr_busy, wr_done, wr_error;
   logic [11:0] wr_mem_addr;
   logic [7:0]  wr_mem_wdata;
   logic [12:0] wr_byte_count;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   int          hsCyc[$];
   int          wCyc[$];
   logic [11:0] wAddr[$];
   logic [7:0]  wData[$];
   logic [11:0] wrAddr[$];
   logic [7:0]  wrData[$];

   imem_loader #(.ADDRESS_WIDTH(12), .DATA_WIDTH(8), .BASE_ADDR(12'h000)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error), .byte_count(byte_count)
   );

   imem_loader #(.ADDRESS_WIDTH(12), .DATA_WIDTH(8), .BASE_ADDR(12'hFFE)) dutWrap (
      .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(wr_rx_ready), .mem_addr(wr_mem_addr), .mem_wdata(wr_mem_wdata),
      .mem_we(wr_mem_we), .cpu_hold(wr_cpu_hold), .busy(wr_busy), .done(wr_done),
      .error(wr_error), .byte_count(wr_byte_count)
   );

   // Free-running clock with a cycle index used to measure write latency.
   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   // Observe handshakes and writes mid-cycle, well away from the active edge.
   always @(negedge clk) begin
      if (rx_valid && rx_ready) hsCyc.push_back(cyc);
      if (mem_we) begin
         wCyc.push_back(cyc);
         wAddr.push_back(mem_addr);
         wData.push_back(mem_wdata);
      end
      if (wr_mem_we) begin
         wrAddr.push_back(wr_mem_addr);
         wrData.push_back(wr_mem_wdata);
      end
   end

   // Hard time limit so a stuck design still ends the run.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic clearLog();
      hsCyc.delete();
      wCyc.delete();
      wAddr.delete();
      wData.delete();
      wrAddr.delete();
      wrData.delete();
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulseStart();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   // Offers each byte until accepted; optional idle cycle between bytes.
   task automatic sendFrame(input logic [7:0] bytes[$], input bit gap);
      int n;
      foreach (bytes[i]) begin
         n        = 0;
         rx_data  = bytes[i];
         rx_valid = 1'b1;
         @(negedge clk);
         while (!rx_ready && n < 20) begin
            @(negedge clk);
            n++;
         end
         if (!rx_ready) begin
            checks++;
            failures++;
            $display("[TB] FAIL send_timeout byte %0d: rx_ready=%b required 1", i, rx_ready);
            rx_valid = 1'b0;
            return;
         end
         tick(1);
         if (gap) begin
            rx_valid = 1'b0;
            tick(1);
         end
      end
      rx_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      #2 rst_n = 1'b0;
      tick(2);
      checks++;
      if ({rx_ready, mem_we, cpu_hold, busy, done, error} !== 6'b0) begin
         failures++;
         $display("[TB] FAIL reset_flags: got %b required 000000",
                  {rx_ready, mem_we, cpu_hold, busy, done, error});
      end
      checks++;
      if ({mem_addr, mem_wdata, byte_count} !== 33'b0) begin
         failures++;
         $display("[TB] FAIL reset_values: addr=%h wdata=%h count=%0d required 0/0/0",
                  mem_addr, mem_wdata, byte_count);
      end
      rst_n = 1'b1;
      tick(1);
   endtask

   task automatic test_basic_load();
      logic [7:0] f[$];
      logic [7:0] expD[4] = '{8'h13, 8'h05, 8'hA0, 8'h00};
      bit ok;
      clearLog();
      pulseStart();
      checks++;
      if ({busy, cpu_hold, rx_ready} !== 3'b111) begin
         failures++;
         $display("[TB] FAIL basic_after_start: busy/hold/ready=%b required 111",
                  {busy, cpu_hold, rx_ready});
      end
      f = '{8'h04, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB6};
      sendFrame(f, 1'b0);
      checks++;
      if ({done, error, cpu_hold, busy} !== 4'b1000) begin
         failures++;
         $display("[TB] FAIL basic_status: done/err/hold/busy=%b required 1000",
                  {done, error, cpu_hold, busy});
      end
      checks++;
      if (byte_count !== 13'd4) begin
         failures++;
         $display("[TB] FAIL basic_count: got %0d required 4", byte_count);
      end
      checks++;
      if (wAddr.size() != 4 || hsCyc.size() != 7) begin
         failures++;
         $display("[TB] FAIL basic_write_count: writes=%0d handshakes=%0d required 4/7",
                  wAddr.size(), hsCyc.size());
      end else begin
         ok = 1'b1;
         for (int i = 0; i < 4; i++)
            if (wAddr[i] !== 12'(i) || wData[i] !== expD[i]) ok = 1'b0;
         checks++;
         if (!ok) begin
            failures++;
            $display("[TB] FAIL basic_writes: first addr=%h data=%h required 000/13 onward",
                     wAddr[0], wData[0]);
         end
         ok = 1'b1;
         for (int i = 0; i < 4; i++)
            if (wCyc[i] != hsCyc[i+2] + 1) ok = 1'b0;
         checks++;
         if (!ok) begin
            failures++;
            $display("[TB] FAIL basic_latency: write cycle %0d handshake cycle %0d required +1",
                     wCyc[0], hsCyc[2]);
         end
      end
   endtask

   task automatic test_bad_checksum();
      logic [7:0] f[$];
      clearLog();
      pulseStart();
      f = '{8'h04, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h00};
      sendFrame(f, 1'b0);
      tick(1);
      checks++;
      if ({done, error, cpu_hold, busy, rx_ready} !== 5'b01100) begin
         failures++;
         $display("[TB] FAIL badsum_status: done/err/hold/busy/ready=%b required 01100",
                  {done, error, cpu_hold, busy, rx_ready});
      end
      checks++;
      if (wAddr.size() != 4) begin
         failures++;
         $display("[TB] FAIL badsum_writes: got %0d required 4", wAddr.size());
      end
      pulseStart();
      checks++;
      if ({done, error, byte_count} !== 15'b0) begin
         failures++;
         $display("[TB] FAIL restart_clear: done=%b err=%b count=%0d required 0/0/0",
                  done, error, byte_count);
      end
      f = '{8'h02, 8'h00, 8'h5A, 8'h0F, 8'h55};
      sendFrame(f, 1'b0);
      checks++;
      if ({done, error, cpu_hold} !== 3'b100) begin
         failures++;
         $display("[TB] FAIL retry_status: done/err/hold=%b required 100",
                  {done, error, cpu_hold});
      end
   endtask

   task automatic test_zero_length();
      logic [7:0] f[$];
      clearLog();
      pulseStart();
      f = '{8'h00, 8'h00, 8'h00};
      sendFrame(f, 1'b0);
      tick(1);
      checks++;
      if ({done, error, cpu_hold, busy} !== 4'b1000 || byte_count !== 13'd0) begin
         failures++;
         $display("[TB] FAIL zero_status: done/err/hold/busy=%b count=%0d required 1000/0",
                  {done, error, cpu_hold, busy}, byte_count);
      end
      checks++;
      if (wAddr.size() != 0) begin
         failures++;
         $display("[TB] FAIL zero_writes: got %0d required 0", wAddr.size());
      end
   endtask

   task automatic test_oversize();
      logic [7:0] f[$];
      clearLog();
      pulseStart();
      f = '{8'h01, 8'h10};
      sendFrame(f, 1'b0);
      checks++;
      if ({done, error, cpu_hold, busy, rx_ready} !== 5'b01100) begin
         failures++;
         $display("[TB] FAIL oversize_status: done/err/hold/busy/ready=%b required 01100",
                  {done, error, cpu_hold, busy, rx_ready});
      end
      rx_valid = 1'b1;
      rx_data  = 8'hAA;
      tick(3);
      rx_valid = 1'b0;
      checks++;
      if (wAddr.size() != 0 || hsCyc.size() != 2) begin
         failures++;
         $display("[TB] FAIL oversize_traffic: writes=%0d handshakes=%0d required 0/2",
                  wAddr.size(), hsCyc.size());
      end
   endtask

   task automatic test_stalls();
      logic [7:0] f[$];
      bit ok;
      clearLog();
      pulseStart();
      f = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
      sendFrame(f, 1'b1);
      checks++;
      if (done !== 1'b1 || byte_count !== 13'd3) begin
         failures++;
         $display("[TB] FAIL stall_status: done=%b count=%0d required 1/3", done, byte_count);
      end
      checks++;
      if (wAddr.size() != 3 || hsCyc.size() != 6) begin
         failures++;
         $display("[TB] FAIL stall_counts: writes=%0d handshakes=%0d required 3/6",
                  wAddr.size(), hsCyc.size());
      end else begin
         ok = (wAddr[0] === 12'h000) && (wAddr[1] === 12'h001) && (wAddr[2] === 12'h002) &&
              (wData[0] === 8'h11) && (wData[1] === 8'h22) && (wData[2] === 8'h33);
         checks++;
         if (!ok) begin
            failures++;
            $display("[TB] FAIL stall_writes: addr %h %h %h required 000 001 002",
                     wAddr[0], wAddr[1], wAddr[2]);
         end
      end
      rx_valid = 1'b1;
      rx_data  = 8'h77;
      tick(2);
      checks++;
      if (rx_ready !== 1'b0 || hsCyc.size() != 6) begin
         failures++;
         $display("[TB] FAIL done_ignores_rx: ready=%b handshakes=%0d required 0/6",
                  rx_ready, hsCyc.size());
      end
      rx_valid = 1'b0;
   endtask

   task automatic test_start_during_data();
      logic [7:0] f[$];
      clearLog();
      pulseStart();
      f = '{8'h04, 8'h00, 8'h01, 8'h02};
      sendFrame(f, 1'b0);
      pulseStart();
      checks++;
      if (busy !== 1'b1 || byte_count !== 13'd2) begin
         failures++;
         $display("[TB] FAIL start_in_data: busy=%b count=%0d required 1/2", busy, byte_count);
      end
      f = '{8'h03, 8'h04, 8'h04};
      sendFrame(f, 1'b0);
      checks++;
      if (done !== 1'b1 || byte_count !== 13'd4 || wAddr.size() != 4) begin
         failures++;
         $display("[TB] FAIL start_in_data_end: done=%b count=%0d writes=%0d required 1/4/4",
                  done, byte_count, wAddr.size());
      end
   endtask

   task automatic test_wrap();
      logic [7:0] f[$];
      clearLog();
      pulseStart();
      f = '{8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
      sendFrame(f, 1'b0);
      checks++;
      if (wrAddr.size() != 4) begin
         failures++;
         $display("[TB] FAIL wrap_count: got %0d required 4", wrAddr.size());
      end else begin
         checks++;
         if (wrAddr[0] !== 12'hFFE || wrAddr[1] !== 12'hFFF ||
             wrAddr[2] !== 12'h000 || wrAddr[3] !== 12'h001 || wrData[3] !== 8'h04) begin
            failures++;
            $display("[TB] FAIL wrap_addr: got %h %h %h %h required FFE FFF 000 001",
                     wrAddr[0], wrAddr[1], wrAddr[2], wrAddr[3]);
         end
      end
      checks++;
      if (wr_done !== 1'b1 || wr_byte_count !== 13'd4 ||
          {wr_busy, wr_cpu_hold, wr_error, wr_rx_ready} !== 4'b0000) begin
         failures++;
         $display("[TB] FAIL wrap_status: done=%b count=%0d busy/hold/err/ready=%b required 1/4/0000",
                  wr_done, wr_byte_count, {wr_busy, wr_cpu_hold, wr_error, wr_rx_ready});
      end
   endtask

   task automatic test_full_capacity();
      logic [7:0] f[$];
      bit ok;
      clearLog();
      pulseStart();
      f.push_back(8'h00);
      f.push_back(8'h10);
      for (int i = 0; i < 4096; i++) f.push_back(8'(i));
      f.push_back(8'h00);
      sendFrame(f, 1'b0);
      checks++;
      if (done !== 1'b1 || error !== 1'b0 || byte_count !== 13'h1000) begin
         failures++;
         $display("[TB] FAIL full_status: done=%b err=%b count=%0d required 1/0/4096",
                  done, error, byte_count);
      end
      checks++;
      if (wAddr.size() != 4096 || wrAddr.size() != 4096) begin
         failures++;
         $display("[TB] FAIL full_count: writes=%0d wrap_writes=%0d required 4096/4096",
                  wAddr.size(), wrAddr.size());
      end else begin
         ok = 1'b1;
         for (int i = 0; i < 4096; i++)
            if (wAddr[i] !== 12'(i) || wData[i] !== 8'(i)) ok = 1'b0;
         checks++;
         if (!ok || wAddr[4095] !== 12'hFFF) begin
            failures++;
            $display("[TB] FAIL full_contiguous: last addr=%h required FFF", wAddr[4095]);
         end
         checks++;
         if (wrAddr[4095] !== 12'hFFD) begin
            failures++;
            $display("[TB] FAIL full_wrap_last: got %h required FFD", wrAddr[4095]);
         end
      end
   endtask

   task automatic test_reset_mid_load();
      logic [7:0] f[$];
      clearLog();
      pulseStart();
      f = '{8'h08, 8'h00, 8'hC1, 8'hC2};
      sendFrame(f, 1'b0);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({rx_ready, mem_we, cpu_hold, busy, done, error} !== 6'b0 ||
          {mem_addr, mem_wdata, byte_count} !== 33'b0) begin
         failures++;
         $display("[TB] FAIL midreset_outputs: flags=%b addr=%h wdata=%h count=%0d required all 0",
                  {rx_ready, mem_we, cpu_hold, busy, done, error}, mem_addr, mem_wdata, byte_count);
      end
      clearLog();
      rx_valid = 1'b1;
      rx_data  = 8'h55;
      tick(2);
      rst_n = 1'b1;
      tick(4);
      checks++;
      if (wAddr.size() != 0 || hsCyc.size() != 0) begin
         failures++;
         $display("[TB] FAIL midreset_no_writes: writes=%0d handshakes=%0d required 0/0",
                  wAddr.size(), hsCyc.size());
      end
      checks++;
      if ({rx_ready, busy, cpu_hold, done, error} !== 5'b0) begin
         failures++;
         $display("[TB] FAIL idle_ignores_rx: ready/busy/hold/done/err=%b required 00000",
                  {rx_ready, busy, cpu_hold, done, error});
      end
      rx_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic_load();
      test_bad_checksum();
      test_zero_length();
      test_oversize();
      test_stalls();
      test_start_during_data();
      test_wrap();
      test_full_capacity();
      test_reset_mid_load();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
